// File: rtl/mux_scan_if.sv
// Handshake bundle for mux_scan: channel data/select/enables in, registered word plus valid/ready out.
interface mux_scan_if #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      mode;
    logic [SEL_W-1:0]          s;
    logic [CHANNELS*WIDTH-1:0] din;
    logic [CHANNELS-1:0]       ch_en;
    logic                      out_ready;
    logic [WIDTH-1:0]          f;
    logic [SEL_W-1:0]          f_ch;
    logic                      f_valid;

    modport master (
        output mode, s, din, ch_en, out_ready,
        input  f, f_ch, f_valid
    );

    modport slave (
        input  mode, s, din, ch_en, out_ready,
        output f, f_ch, f_valid
    );
endinterface

// File: rtl/mux_scan.sv
// Channel multiplexer with a one-word registered output stage; manual select or round-robin scan
// over an enable mask, with valid/ready backpressure.
module mux_scan #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input logic       clk,
    input logic       rst,
    mux_scan_if.slave bus
);
    logic [WIDTH-1:0] f_q, f_d;
    logic [SEL_W-1:0] fCh_q, fCh_d;
    logic             fValid_q, fValid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             loadSlot;
    logic             found;
    logic [SEL_W-1:0] scanIdx;
    int               nextIdx;
    logic [WIDTH-1:0] chanData [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign chanData[k] = bus.din[k*WIDTH +: WIDTH];
    end

    // A new word may enter only when the stage is empty or its current word leaves this edge.
    assign loadSlot = !fValid_q || bus.out_ready;

    always_comb begin
        f_d      = f_q;
        fCh_d    = fCh_q;
        fValid_d = fValid_q;
        ptr_d    = ptr_q;
        found    = 1'b0;
        scanIdx  = '0;
        nextIdx  = 0;
        if (loadSlot) begin
            if (!bus.mode) begin
                if ({1'b0, bus.s} < (SEL_W+1)'(CHANNELS)) begin
                    f_d      = chanData[bus.s];
                    fCh_d    = bus.s;
                    fValid_d = 1'b1;
                end else begin
                    fValid_d = 1'b0;
                end
            end else begin
                fValid_d = 1'b0;
                // Search starts just after the last served channel and ends on that channel itself.
                for (int i = 1; i <= CHANNELS; i++) begin
                    nextIdx = (int'(ptr_q) + i) % CHANNELS;
                    scanIdx = SEL_W'(nextIdx);
                    if (!found && bus.ch_en[scanIdx]) begin
                        found    = 1'b1;
                        f_d      = chanData[scanIdx];
                        fCh_d    = scanIdx;
                        ptr_d    = scanIdx;
                        fValid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q      <= '0;
            fCh_q    <= '0;
            fValid_q <= 1'b0;
            ptr_q    <= SEL_W'(CHANNELS - 1);
        end else begin
            f_q      <= f_d;
            fCh_q    <= fCh_d;
            fValid_q <= fValid_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.f       = f_q;
    assign bus.f_ch    = fCh_q;
    assign bus.f_valid = fValid_q;
endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: stimulus pushes expected words into a scoreboard queue that a
// negedge monitor drains on every transfer; hold, reset and empty-slot cases are checked inline.
module tb_mux_scan;
    typedef struct {
        int ch;
        int data;
    } expWord_t;

    logic     clk;
    logic     rst;
    int       checks;
    int       errors;
    expWord_t expQ[$];
    expWord_t monWord;

    mux_scan_if #(.WIDTH(3), .CHANNELS(4), .SEL_W(2)) bus0 ();
    mux_scan_if #(.WIDTH(3), .CHANNELS(3), .SEL_W(2)) bus3 ();

    mux_scan #(.WIDTH(3), .CHANNELS(4), .SEL_W(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    mux_scan #(.WIDTH(3), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [1:0] sel, input logic [3:0] en,
                                 input logic rdy);
        bus0.mode      = m;
        bus0.s         = sel;
        bus0.ch_en     = en;
        bus0.out_ready = rdy;
    endtask

    task automatic expectWord(input int ch, input int data);
        expQ.push_back('{ch: ch, data: data});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus0.f_valid && bus0.out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected word: got f=%0d f_ch=%0d, expected none",
                         bus0.f, bus0.f_ch);
            end else begin
                monWord = expQ.pop_front();
                checkOutput("scoreboard f", int'(bus0.f), monWord.data);
                checkOutput("scoreboard f_ch", int'(bus0.f_ch), monWord.ch);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus0.din = {3'd4, 3'd3, 3'd2, 3'd1};
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b0);
        bus3.din       = {3'd3, 3'd2, 3'd1};
        bus3.mode      = 1'b0;
        bus3.s         = 2'd3;
        bus3.ch_en     = 3'b000;
        bus3.out_ready = 1'b1;

        #12;
        checkOutput("reset f", int'(bus0.f), 0);
        checkOutput("reset f_ch", int'(bus0.f_ch), 0);
        checkOutput("reset f_valid", int'(bus0.f_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();
        checkOutput("idle f_valid", int'(bus0.f_valid), 0);

        $display("[TB] manual sweep");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'(k), 4'b0000, 1'b1);
            expectWord(k, k + 1);
            nextCycle();
            checkOutput("sweep f_valid", int'(bus0.f_valid), 1);
        end
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        nextCycle();
        checkOutput("drain f_valid", int'(bus0.f_valid), 0);
        checkOutput("drain f hold", int'(bus0.f), 4);
        checkOutput("drain f_ch hold", int'(bus0.f_ch), 3);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 2'd2, 4'b0000, 1'b0);
        expectWord(2, 3);
        nextCycle();
        applyStimulus(1'b0, 2'd3, 4'b1111, 1'b0);
        bus0.din = {3'd4, 3'd7, 3'd2, 3'd1};
        for (int c = 0; c < 3; c++) begin
            nextCycle();
            checkOutput("hold f", int'(bus0.f), 3);
            checkOutput("hold f_ch", int'(bus0.f_ch), 2);
            checkOutput("hold f_valid", int'(bus0.f_valid), 1);
        end
        applyStimulus(1'b0, 2'd3, 4'b0000, 1'b1);
        expectWord(3, 4);
        nextCycle();
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        nextCycle();
        checkOutput("post-hold f_valid", int'(bus0.f_valid), 0);
        bus0.din = {3'd4, 3'd3, 3'd2, 3'd1};

        $display("[TB] scan skip and wrap");
        applyStimulus(1'b1, 2'd0, 4'b1011, 1'b1);
        for (int r = 0; r < 2; r++) begin
            expectWord(0, 1);
            expectWord(1, 2);
            expectWord(3, 4);
        end
        repeat (6) nextCycle();
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        nextCycle();
        checkOutput("empty mask f_valid", int'(bus0.f_valid), 0);
        checkOutput("empty mask f hold", int'(bus0.f), 4);
        checkOutput("empty mask f_ch hold", int'(bus0.f_ch), 3);

        $display("[TB] single enabled channel");
        applyStimulus(1'b1, 2'd0, 4'b0100, 1'b1);
        repeat (3) expectWord(2, 3);
        repeat (3) nextCycle();
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        nextCycle();
        checkOutput("single drain f_valid", int'(bus0.f_valid), 0);

        $display("[TB] async reset mid-handshake");
        applyStimulus(1'b0, 2'd1, 4'b0000, 1'b0);
        nextCycle();
        checkOutput("pre-reset f", int'(bus0.f), 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset f", int'(bus0.f), 0);
        checkOutput("async reset f_ch", int'(bus0.f_ch), 0);
        checkOutput("async reset f_valid", int'(bus0.f_valid), 0);
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        expectWord(0, 1);
        nextCycle();
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        nextCycle();
        checkOutput("post-reset drain f_valid", int'(bus0.f_valid), 0);

        $display("[TB] out-of-range select, three channels");
        bus3.s = 2'd1;
        nextCycle();
        checkOutput("ch3 load f", int'(bus3.f), 2);
        checkOutput("ch3 load f_ch", int'(bus3.f_ch), 1);
        checkOutput("ch3 load f_valid", int'(bus3.f_valid), 1);
        bus3.s = 2'd3;
        nextCycle();
        checkOutput("ch3 oor f_valid", int'(bus3.f_valid), 0);
        checkOutput("ch3 oor f hold", int'(bus3.f), 2);
        checkOutput("ch3 oor f_ch hold", int'(bus3.f_ch), 1);

        nextCycle();
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
